// File: rtl/compressed_word_packer_pkg.sv
// Shared constants, state encoding and helpers for the compressed-code word packer.
package compressed_word_packer_pkg;

    localparam int IN_WIDTH   = 68;   // widest chunk accepted from the encoder
    localparam int OUT_WIDTH  = 68;   // emitted word width
    localparam int ACC_WIDTH  = 136;  // two output words: worst-case fill is 135
    localparam int LEN_WIDTH  = 7;    // chunk length / o_bits field
    localparam int CNT_WIDTH  = 8;    // per-block output word counter
    localparam int FILL_WIDTH = 8;    // fill runs 0..135, one bit wider than LEN_WIDTH

    typedef enum logic {
        ACCUM = 1'b0,   // packing chunks, emitting full words as they complete
        FLUSH = 1'b1    // block ended: draining residual words, input closed
    } state_e;

    // Ones in the low 'len' bit positions; strips garbage above the chunk length.
    function automatic logic [IN_WIDTH-1:0] len_mask(input logic [LEN_WIDTH-1:0] len);
        logic [IN_WIDTH-1:0] mask;
        for (int i = 0; i < IN_WIDTH; i++) begin
            mask[i] = (i < int'(len));
        end
        return mask;
    endfunction

endpackage

// File: rtl/compressed_word_packer_if.sv
// Chunk-in / word-out handshake bundle of the packer. 'slave' is the packer side,
// 'master' is the surrounding encoder plus downstream consumer.
interface compressed_word_packer_if;
    import compressed_word_packer_pkg::*;

    // chunk channel (encoder -> packer)
    logic                 i_valid;
    logic                 o_ready;
    logic [IN_WIDTH-1:0]  i_data;
    logic [LEN_WIDTH-1:0] i_len;
    logic                 i_last;

    // word channel (packer -> downstream)
    logic                 o_valid;
    logic                 i_ready;
    logic [OUT_WIDTH-1:0] o_word;
    logic [LEN_WIDTH-1:0] o_bits;
    logic                 o_last;
    logic [CNT_WIDTH-1:0] o_word_cnt;

    modport slave (
        input  i_valid, i_data, i_len, i_last, i_ready,
        output o_ready, o_valid, o_word, o_bits, o_last, o_word_cnt
    );

    modport master (
        output i_valid, i_data, i_len, i_last, i_ready,
        input  o_ready, o_valid, o_word, o_bits, o_last, o_word_cnt
    );

endinterface

// File: rtl/compressed_word_packer_pack_shift_insert.sv
// Combinational aligner: masks a chunk to its length, places its MSB at
// accumulator bit (ACC_WIDTH-1-fill) and ORs it into the accumulator.
module pack_shift_insert
    import compressed_word_packer_pkg::*;
(
    input  logic [ACC_WIDTH-1:0]  acc_in,
    input  logic [FILL_WIDTH-1:0] fill,
    input  logic [IN_WIDTH-1:0]   data,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic [ACC_WIDTH-1:0]  acc_out
);

    logic [ACC_WIDTH-1:0]  chunk_wide;
    logic [ACC_WIDTH-1:0]  chunk_aligned;
    logic [FILL_WIDTH-1:0] top_shift;

    // Push the chunk MSB to the accumulator top, then slide it down by the fill.
    // A zero-length chunk shifts fully out and contributes nothing.
    always_comb begin
        chunk_wide    = {{(ACC_WIDTH-IN_WIDTH){1'b0}}, data & len_mask(len)};
        top_shift     = FILL_WIDTH'(ACC_WIDTH) - FILL_WIDTH'(len);
        chunk_aligned = (chunk_wide << top_shift) >> fill;
        acc_out       = acc_in | chunk_aligned;
    end

endmodule

// File: rtl/compressed_word_packer.sv
// Packs variable-length compressed chunks MSB-first into fixed 68-bit words;
// a block-end marker flushes the residual partial word with its bit count.
module compressed_word_packer
    import compressed_word_packer_pkg::*;
(
    input logic                     i_clk,
    input logic                     i_rst_n,
    compressed_word_packer_if.slave bus
);

    localparam logic [FILL_WIDTH-1:0] FILL_OUT = FILL_WIDTH'(OUT_WIDTH);

    state_e                state_q, state_d;
    logic [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic [FILL_WIDTH-1:0] fill_q, fill_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  alive_q, alive_d;

    logic                  word_full;
    logic                  out_valid;
    logic                  out_last;
    logic                  in_ready;
    logic                  emit;
    logic                  accept;
    logic [LEN_WIDTH-1:0]  len_eff;
    logic [ACC_WIDTH-1:0]  acc_shift;
    logic [FILL_WIDTH-1:0] fill_shift;
    logic [ACC_WIDTH-1:0]  acc_ins;

    // Handshake decode; o_ready follows i_ready combinationally when a full word leaves.
    always_comb begin
        word_full = (fill_q >= FILL_OUT);
        out_valid = (state_q == FLUSH) || word_full;
        out_last  = (state_q == FLUSH) && (fill_q <= FILL_OUT);
        emit      = out_valid && bus.i_ready;
        in_ready  = alive_q && (state_q == ACCUM) && (!word_full || emit);
        accept    = bus.i_valid && in_ready;
        // an out-of-range length is clamped so the fill can never pass 135
        len_eff   = (bus.i_len > LEN_WIDTH'(IN_WIDTH)) ? LEN_WIDTH'(IN_WIDTH) : bus.i_len;
    end

    // Emit stage: retire the top word before any same-cycle insert lands below it.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        acc_shift  = acc_q;
        fill_shift = fill_q;
        if (emit) begin
            acc_shift  = acc_q << OUT_WIDTH;
            fill_shift = word_full ? (fill_q - FILL_OUT) : '0;
        end
    end

    pack_shift_insert u_insert (
        .acc_in  (acc_shift),
        .fill    (fill_shift),
        .data    (bus.i_data),
        .len     (len_eff),
        .acc_out (acc_ins)
    );

    // Next-state: accumulator/fill update, block FSM and saturating word counter.
    always_comb begin
        acc_d   = accept ? acc_ins : acc_shift;
        fill_d  = accept ? (fill_shift + FILL_WIDTH'(len_eff)) : fill_shift;
        state_d = state_q;
        cnt_d   = cnt_q;
        alive_d = 1'b1;
        if (accept && bus.i_last) begin
            state_d = FLUSH;
        end
        if (emit) begin
            if (out_last) begin
                state_d = ACCUM;
                cnt_d   = '0;
            end else if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    // State registers; reset discards any buffered bits of a partial block.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ACCUM;
            // NOTE: the accumulator is reset, not left X, because inserts OR into it.
            acc_q   <= '0;
            fill_q  <= '0;
            cnt_q   <= '0;
            alive_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            state_q <= state_d;
            acc_q   <= acc_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
            alive_q <= alive_d;
        end
    end

    assign bus.o_ready    = in_ready;
    assign bus.o_valid    = out_valid;
    assign bus.o_word     = acc_q[ACC_WIDTH-1 -: OUT_WIDTH];
    assign bus.o_bits     = word_full ? LEN_WIDTH'(OUT_WIDTH) : fill_q[LEN_WIDTH-1:0];
    assign bus.o_last     = out_last;
    assign bus.o_word_cnt = (out_valid && (cnt_q != '1)) ? (cnt_q + CNT_WIDTH'(1)) : cnt_q;

endmodule
